id_reg_reader: RTL and testbench
================================

Name: id_reg_reader

Overview:
- Read side of the architectural register file; consumes the write-back triple (wb_en, wb_addr, wb_data) from the MEM/WB pipeline register.
- Sits in ID: holds the 32x32 register file, reads rs1/rs2 for the instruction in decode, and tracks pending writes in a per-register scoreboard to stall RAW/WAW hazards.
- Presents operands to EX through a valid/ready-registered ID/EX output stage.

Parameters:
- SB_W, 2, width of each per-register pending-write counter; max in-flight writers per register = 2^SB_W-1.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wb_en  input  1  write-back enable
- wb_addr  input  5  write-back register index
- wb_data  input  XLEN  write-back data
- id_valid  input  1  decode holds a valid instruction
- id_ready  output  1  instruction accepted this cycle (combinational)
- rs1_addr, rs2_addr  input  5 each  source indices
- rs1_used, rs2_used  input  1 each  source is actually read
- rd_addr  input  5  destination index
- rd_wen  input  1  instruction writes rd
- flush  input  1  kill the instruction held in the ID/EX stage
- ex_ready  input  1  EX accepts ex_* this cycle
- ex_valid  output  1  ex_* holds a valid instruction
- ex_rs1_data, ex_rs2_data  output  XLEN each  operands
- ex_rd_addr  output  5  destination
- ex_rd_wen  output  1  destination write flag
- stall_raw  output  1  decode blocked by a scoreboard hazard (debug/perf)

Behaviour:
- Reset (rst=1 at an edge): all 32 registers = 0, all counters = 0, ex_valid = 0, ex_rs1_data = ex_rs2_data = 0, ex_rd_addr = 0, ex_rd_wen = 0.
- Reset dominates wb_en, issue and flush in the same cycle.
- Register file write: if wb_en & wb_addr!=0, reg[wb_addr] <= wb_data at the edge.
- x0 reads 0 always and is never written, counted or hazarded.
- Read: rdata = (addr==0) ? 0 : reg[addr], with optional same-cycle bypass (see Optional Feature).
- busy(r) = cnt[r]!=0, excluding the bypass-resolved case.
- Hazard cases:
  - rs1_used & busy(rs1).
  - rs2_used & busy(rs2).
  - rd_wen & rd!=0 & cnt[rd] == 2^SB_W-1 (saturation / WAW overflow).
- stall_raw = id_valid & hazard.
- id_ready = ~hazard & ~flush & (~ex_valid | ex_ready).
- issue = id_valid & id_ready.
- On issue, ID/EX loads the rs1/rs2 read data, rd_addr, rd_wen and sets ex_valid=1. Latency: decode to ex_* is 1 cycle.
- No issue and ex_ready=1: ex_valid <= 0; data fields hold.
- No issue and ex_ready=0: all ex_* hold.
- flush: ex_valid <= 0 and no issue that cycle.
- flush with ex_valid & ex_rd_wen & ex_rd_addr!=0: that register's counter decrements, because the killed writer will never write back.
- Counter update per register r, as net of inc/dec:
  - inc = issue & rd_wen & rd_addr==r.
  - dec = (wb_en & wb_addr==r) + (flush-kill of r).
  - Simultaneous inc and dec leave the count unchanged. Two decs in one cycle subtract 2.
  - A decrement at 0 holds at 0 and is a protocol error; assertion only.
- Operands from rs==rd of the same instruction read the old value; a self-WAW is not a hazard for its own read.

Optional Feature:
- Macro: REG_RD_BYPASS_EN.
- Defined:
  - A read of r with wb_en & wb_addr==r & r!=0 returns wb_data combinationally.
  - busy(r) excludes cnt[r]==1 & wb_en & wb_addr==r, so the dependent instruction issues in the write-back cycle.
- Undefined:
  - Reads return stored reg[] only.
  - busy(r) = cnt[r]!=0, so the dependent instruction issues one cycle after write-back.

Test Plan:
- Reset, then read x5 and x0 -> ex_rs1_data=0, ex_rs2_data=0, ex_valid=1 one cycle after issue; all counters 0.
- Issue with rd=x3, rd_wen=1; next instruction rs1=x3 -> stall_raw=1, id_ready=0. Then wb_en=1, wb_addr=3, wb_data=0xDEADBEEF:
  - BYPASS_EN: issue in that cycle, ex_rs1_data=0xDEADBEEF.
  - Without BYPASS_EN: issue next cycle with the same value.
- wb_en=1, wb_addr=0, wb_data=0x1234 -> x0 still reads 0; no counter change.
- Three back-to-back writers to x7 with SB_W=2 -> 3rd accepted (cnt=3); 4th stalled until a write-back to x7 arrives.
- Issue a writer to x9, then flush while it is in ID/EX and ex_ready=0 -> ex_valid=0, cnt[9] returns to 0; a reader of x9 issues with no stall.
- ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0, ex_* stable. Then ex_ready=1 -> the pending instruction issues in the same cycle.

Source files
------------

// File: rtl/id_reg_reader_if.sv
// rtl/id_reg_reader_if.sv - decode-stage register read bus bundle
//
// Purpose: groups the write-back, decode-issue and ID/EX output signals of
// id_reg_reader into one bundle.
//   slave  : the register reader (id_reg_reader) view
//   master : the surrounding pipeline / testbench view
// Signals:
//   wb_en, wb_addr, wb_data            write-back triple from MEM/WB
//   id_valid, id_ready                 decode issue handshake
//   rs1_addr, rs2_addr, rs1_used, rs2_used, rd_addr, rd_wen
//                                      decoded instruction fields
//   flush                              kill the ID/EX entry
//   ex_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_rd_wen
//                                      ID/EX output stage handshake and fields
//   stall_raw                          decode blocked by scoreboard hazard
interface id_reg_reader_if #(
   parameter int XLEN = 32
);
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;

   logic            id_valid;
   logic            id_ready;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic            rs1_used;
   logic            rs2_used;
   logic [4:0]      rd_addr;
   logic            rd_wen;

   logic            flush;
   logic            ex_ready;
   logic            ex_valid;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [4:0]      ex_rd_addr;
   logic            ex_rd_wen;
   logic            stall_raw;

   modport slave (
      input  wb_en, wb_addr, wb_data,
      input  id_valid, rs1_addr, rs2_addr, rs1_used, rs2_used, rd_addr, rd_wen,
      input  flush, ex_ready,
      output id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_rd_wen,
      output stall_raw
   );

   modport master (
      output wb_en, wb_addr, wb_data,
      output id_valid, rs1_addr, rs2_addr, rs1_used, rs2_used, rd_addr, rd_wen,
      output flush, ex_ready,
      input  id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_rd_wen,
      input  stall_raw
   );
endinterface

// File: rtl/id_reg_reader.sv
// rtl/id_reg_reader.sv - ID-stage register file reader with write scoreboard
//
// Purpose: holds the 32 x XLEN architectural register file, reads rs1/rs2 for
// the instruction in decode, tracks in-flight writers per register with a
// saturating SB_W-bit counter, stalls RAW hazards and writer overflow, and
// presents operands to EX through a registered valid/ready ID/EX stage.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - id_reg_reader_if.slave: write-back triple, decode fields and
//          handshake, flush, ID/EX outputs, stall_raw
// Build option:
//   REG_RD_BYPASS_EN - when defined, a read of the register being written
//   back this cycle returns wb_data, and a last pending writer that is
//   writing back this cycle no longer blocks its readers.
module id_reg_reader #(
   parameter int SB_W = 2,
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   id_reg_reader_if.slave bus
);
   localparam logic [SB_W-1:0] CNT_MAX = '1;
   localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

   logic [XLEN-1:0] regs [32];
   logic [SB_W-1:0] cnt [32];
   logic [SB_W-1:0] cnt_next [32];

   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            rd_full;
   logic            hazard;
   logic            id_ready_c;
   logic            issue;
   logic            kill;

   logic [31:0]     inc_vec;
   logic [31:0]     wb_vec;
   logic [31:0]     kill_vec;
   logic [31:0]     underflow;
   int              cnt_sum;

   logic            ex_valid_q;
   logic [XLEN-1:0] ex_rs1_q;
   logic [XLEN-1:0] ex_rs2_q;
   logic [4:0]      ex_rd_addr_q;
   logic            ex_rd_wen_q;

   // Operand read and busy evaluation; x0 is never busy and always reads 0.
   always_comb begin
      rs1_data = (bus.rs1_addr == 5'd0) ? '0 : regs[bus.rs1_addr];
      rs2_data = (bus.rs2_addr == 5'd0) ? '0 : regs[bus.rs2_addr];
      rs1_busy = (bus.rs1_addr != 5'd0) && (cnt[bus.rs1_addr] != '0);
      rs2_busy = (bus.rs2_addr != 5'd0) && (cnt[bus.rs2_addr] != '0);
`ifdef REG_RD_BYPASS_EN
      if (bus.wb_en && bus.wb_addr == bus.rs1_addr && bus.rs1_addr != 5'd0) begin
         rs1_data = bus.wb_data;
         if (cnt[bus.rs1_addr] == CNT_ONE) rs1_busy = 1'b0;
      end
      if (bus.wb_en && bus.wb_addr == bus.rs2_addr && bus.rs2_addr != 5'd0) begin
         rs2_data = bus.wb_data;
         if (cnt[bus.rs2_addr] == CNT_ONE) rs2_busy = 1'b0;
      end
`endif
      // Saturation is judged on the current count; a same-cycle write-back
      // to rd frees the slot only from the next cycle.
      rd_full    = bus.rd_wen && (bus.rd_addr != 5'd0) && (cnt[bus.rd_addr] == CNT_MAX);
      hazard     = (bus.rs1_used && rs1_busy) || (bus.rs2_used && rs2_busy) || rd_full;
      id_ready_c = !hazard && !bus.flush && (!ex_valid_q || bus.ex_ready);
      issue      = bus.id_valid && id_ready_c;
      kill       = bus.flush && ex_valid_q && ex_rd_wen_q && (ex_rd_addr_q != 5'd0);
   end

   assign bus.id_ready    = id_ready_c;
   assign bus.stall_raw   = bus.id_valid && hazard;
   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_rs1_data = ex_rs1_q;
   assign bus.ex_rs2_data = ex_rs2_q;
   assign bus.ex_rd_addr  = ex_rd_addr_q;
   assign bus.ex_rd_wen   = ex_rd_wen_q;

   // Net counter update: one possible increment (issue) against up to two
   // decrements (write-back and flush-kill of the ID/EX writer).
   always_comb begin
      cnt_sum   = 0;
      inc_vec   = '0;
      wb_vec    = '0;
      kill_vec  = '0;
      underflow = '0;
      for (int r = 0; r < 32; r++) begin
         cnt_next[r] = '0;
         if (r != 0) begin
            inc_vec[r]  = issue && bus.rd_wen && (bus.rd_addr == 5'(r));
            wb_vec[r]   = bus.wb_en && (bus.wb_addr == 5'(r));
            kill_vec[r] = kill && (ex_rd_addr_q == 5'(r));
            cnt_sum = int'(cnt[r]) + int'(inc_vec[r]) - int'(wb_vec[r]) - int'(kill_vec[r]);
            if (cnt_sum < 0) begin
               underflow[r] = 1'b1;
               cnt_sum = 0;
            end
            cnt_next[r] = SB_W'(cnt_sum);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < 32; r++) begin
         cnt[r] <= rst ? '0 : cnt_next[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) regs[r] <= '0;
      end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_rd_addr_q <= '0;
         ex_rd_wen_q  <= 1'b0;
      end else if (bus.flush) begin
         ex_valid_q   <= 1'b0;
      end else if (issue) begin
         ex_valid_q   <= 1'b1;
         ex_rs1_q     <= rs1_data;
         ex_rs2_q     <= rs2_data;
         ex_rd_addr_q <= bus.rd_addr;
         ex_rd_wen_q  <= bus.rd_wen;
      end else if (bus.ex_ready) begin
         ex_valid_q   <= 1'b0;
      end
   end

   // A write-back or kill for a register with no pending writer means the
   // pipeline lost track of an instruction.
   assert property (@(posedge clk) disable iff (rst) (underflow == 32'd0));
endmodule

// File: tb/tb_id_reg_reader.sv
// tb/tb_id_reg_reader.sv - self-checking bench for id_reg_reader
module tb_id_reg_reader;
   localparam int XLEN = 32;
`ifdef REG_RD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   id_reg_reader_if #(.XLEN(XLEN)) bus ();
   id_reg_reader #(.SB_W(2), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference model: register values, writers already handed to EX, and
   // the ID/EX stage contents.
   logic [31:0] m_regs [32];
   int          post_ex [32];
   bit          m_ex_valid;
   int          m_ex_rd;
   bit          m_ex_wen;
   logic [31:0] m_ex_d1;
   logic [31:0] m_ex_d2;

   function automatic int mcount(int r);
      if (r == 0) return 0;
      return post_ex[r] + ((m_ex_valid && m_ex_wen && m_ex_rd == r) ? 1 : 0);
   endfunction

   function automatic bit mbusy(int r, bit we, int wa);
      if (r == 0 || mcount(r) == 0) return 1'b0;
      return !(BYP && mcount(r) == 1 && we && wa == r);
   endfunction

   function automatic logic [31:0] mread(int r, bit we, int wa, logic [31:0] wd);
      if (r == 0) return 32'd0;
      if (BYP && we && wa == r) return wd;
      return m_regs[r];
   endfunction

   task automatic idle_inputs();
      bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = '0;
      bus.id_valid = 1'b0; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
      bus.rs1_used = 1'b0; bus.rs2_used = 1'b0; bus.rd_addr = 5'd0; bus.rd_wen = 1'b0;
      bus.flush = 1'b0; bus.ex_ready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; post_ex[r] = 0; end
      m_ex_valid = 1'b0; m_ex_rd = 0; m_ex_wen = 1'b0; m_ex_d1 = '0; m_ex_d2 = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
      checks++; if (bus.ex_rs1_data !== 32'd0) begin fails++; $display("FAIL reset_rs1: got %h want 0", bus.ex_rs1_data); end
      checks++; if (bus.ex_rs2_data !== 32'd0) begin fails++; $display("FAIL reset_rs2: got %h want 0", bus.ex_rs2_data); end
      checks++; if (bus.ex_rd_addr !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", bus.ex_rd_addr); end
      checks++; if (bus.ex_rd_wen !== 1'b0) begin fails++; $display("FAIL reset_rd_wen: got %b want 0", bus.ex_rd_wen); end
      for (int r = 1; r < 32; r++) begin
         bus.id_valid = 1'b1; bus.rs1_addr = 5'(r); bus.rs1_used = 1'b1;
         #1;
         checks++; if (bus.stall_raw !== 1'b0) begin fails++; $display("FAIL reset_cnt_x%0d: stall got %b want 0", r, bus.stall_raw); end
      end
      bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0; bus.rs2_used = 1'b1;
      #1;
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL reset_read_ready: got %b want 1", bus.id_ready); end
      tick();
      bus.id_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL reset_read_valid: got %b want 1", bus.ex_valid); end
      checks++; if (bus.ex_rs1_data !== 32'd0) begin fails++; $display("FAIL reset_read_x5: got %h want 0", bus.ex_rs1_data); end
      checks++; if (bus.ex_rs2_data !== 32'd0) begin fails++; $display("FAIL reset_read_x0: got %h want 0", bus.ex_rs2_data); end
   endtask

   task automatic test_raw_bypass();
      apply_reset();
      bus.id_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_wen = 1'b1;
      #1;
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL raw_writer_ready: got %b want 1", bus.id_ready); end
      tick();
      bus.rd_wen = 1'b0; bus.rd_addr = 5'd0; bus.rs1_addr = 5'd3; bus.rs1_used = 1'b1;
      #1;
      checks++; if (bus.stall_raw !== 1'b1) begin fails++; $display("FAIL raw_stall: got %b want 1", bus.stall_raw); end
      checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL raw_ready: got %b want 0", bus.id_ready); end
      tick();
      checks++; if (bus.stall_raw !== 1'b1) begin fails++; $display("FAIL raw_stall2: got %b want 1", bus.stall_raw); end
      bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
      #1;
`ifdef REG_RD_BYPASS_EN
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL raw_wb_ready: got %b want 1", bus.id_ready); end
      tick();
      bus.wb_en = 1'b0; bus.id_valid = 1'b0;
`else
      checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL raw_wb_ready: got %b want 0", bus.id_ready); end
      tick();
      bus.wb_en = 1'b0;
      #1;
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL raw_after_wb_ready: got %b want 1", bus.id_ready); end
      tick();
      bus.id_valid = 1'b0;
`endif
      checks++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL raw_ex_valid: got %b want 1", bus.ex_valid); end
      checks++; if (bus.ex_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL raw_data: got %h want deadbeef", bus.ex_rs1_data); end
   endtask

   task automatic test_x0();
      apply_reset();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
      bus.id_valid = 1'b1; bus.rs1_used = 1'b1; bus.rs2_used = 1'b1;
      bus.rd_addr = 5'd0; bus.rd_wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL x0_ready_%0d: got %b want 1", i, bus.id_ready); end
         tick();
         checks++; if (bus.ex_rs1_data !== 32'd0) begin fails++; $display("FAIL x0_rs1_%0d: got %h want 0", i, bus.ex_rs1_data); end
         checks++; if (bus.ex_rs2_data !== 32'd0) begin fails++; $display("FAIL x0_rs2_%0d: got %h want 0", i, bus.ex_rs2_data); end
      end
      idle_inputs();
   endtask

   task automatic test_saturation();
      apply_reset();
      bus.id_valid = 1'b1; bus.rd_addr = 5'd7; bus.rd_wen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL sat_accept_%0d: got %b want 1", i, bus.id_ready); end
         tick();
      end
      #1;
      checks++; if (bus.stall_raw !== 1'b1) begin fails++; $display("FAIL sat_stall: got %b want 1", bus.stall_raw); end
      checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL sat_ready: got %b want 0", bus.id_ready); end
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h77;
      #1;
      checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL sat_wb_cycle: got %b want 0", bus.id_ready); end
      tick();
      bus.wb_en = 1'b0;
      #1;
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL sat_release: got %b want 1", bus.id_ready); end
      tick();
      bus.id_valid = 1'b0;
      checks++; if (bus.ex_rd_addr !== 5'd7 || bus.ex_rd_wen !== 1'b1) begin fails++; $display("FAIL sat_ex_rd: got %0d/%b want 7/1", bus.ex_rd_addr, bus.ex_rd_wen); end
   endtask

   task automatic test_flush();
      apply_reset();
      bus.id_valid = 1'b1; bus.rd_addr = 5'd9; bus.rd_wen = 1'b1;
      tick();
      bus.rd_addr = 5'd0; bus.rd_wen = 1'b0; bus.ex_ready = 1'b0; bus.flush = 1'b1;
      #1;
      checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", bus.id_ready); end
      tick();
      bus.flush = 1'b0; bus.ex_ready = 1'b1;
      checks++; if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL flush_ex_valid: got %b want 0", bus.ex_valid); end
      bus.rs1_addr = 5'd9; bus.rs1_used = 1'b1;
      #1;
      checks++; if (bus.stall_raw !== 1'b0) begin fails++; $display("FAIL flush_cnt_cleared: stall got %b want 0", bus.stall_raw); end
      tick();
      bus.id_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1) begin fails++; $display("FAIL flush_reader_issue: got %b want 1", bus.ex_valid); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bus.id_valid = 1'b1; bus.rd_addr = 5'd20;
      tick();
      bus.rd_addr = 5'd21; bus.ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.id_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0", i, bus.id_ready); end
         checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd_addr !== 5'd20) begin fails++; $display("FAIL bp_hold_%0d: got %b/%0d want 1/20", i, bus.ex_valid, bus.ex_rd_addr); end
         checks++; if (bus.stall_raw !== 1'b0) begin fails++; $display("FAIL bp_stall_%0d: got %b want 0", i, bus.stall_raw); end
         tick();
      end
      bus.ex_ready = 1'b1;
      #1;
      checks++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", bus.id_ready); end
      tick();
      bus.id_valid = 1'b0;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd_addr !== 5'd21) begin fails++; $display("FAIL bp_next: got %b/%0d want 1/21", bus.ex_valid, bus.ex_rd_addr); end
   endtask

   task automatic test_reset_midrun();
      apply_reset();
      bus.id_valid = 1'b1; bus.rd_addr = 5'd10; bus.rd_wen = 1'b1;
      tick();
      bus.id_valid = 1'b0;
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'hAAAA5555;
      bus.id_valid = 1'b1; bus.rd_addr = 5'd11;
      tick();
      idle_inputs();
      bus.id_valid = 1'b1; bus.rs2_addr = 5'd11; bus.rs2_used = 1'b1;
      #1;
      checks++; if (bus.stall_raw !== 1'b1) begin fails++; $display("FAIL mid_pre_stall: got %b want 1", bus.stall_raw); end
      rst = 1'b1; bus.wb_en = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h1;
      tick();
      rst = 1'b0;
      idle_inputs();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rd_addr !== 5'd0 || bus.ex_rd_wen !== 1'b0) begin fails++; $display("FAIL mid_ex_cleared: got %b/%0d/%b want 0/0/0", bus.ex_valid, bus.ex_rd_addr, bus.ex_rd_wen); end
      bus.id_valid = 1'b1; bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11;
      bus.rs1_used = 1'b1; bus.rs2_used = 1'b1;
      #1;
      checks++; if (bus.stall_raw !== 1'b0) begin fails++; $display("FAIL mid_cnt_cleared: got %b want 0", bus.stall_raw); end
      tick();
      bus.id_valid = 1'b0;
      checks++; if (bus.ex_rs1_data !== 32'd0) begin fails++; $display("FAIL mid_reg_cleared: got %h want 0", bus.ex_rs1_data); end
   endtask

   task automatic test_random();
      int  cand[$];
      int  r1, r2, rdd, wa;
      bit  iv, u1, u2, rw, fl, er, we, hz, exp_ready, exp_stall, iss;
      logic [31:0] wd;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         iv = ($urandom % 4) != 0;
         r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); rdd = $urandom_range(0, 7);
         u1 = $urandom % 2; u2 = $urandom % 2; rw = $urandom % 2;
         fl = ($urandom % 10) == 0; er = ($urandom % 4) != 0;
         cand.delete();
         for (int r = 1; r < 8; r++) if (post_ex[r] > 0) cand.push_back(r);
         we = 1'b0; wa = 0; wd = $urandom;
         if (cand.size() > 0 && ($urandom % 2) == 1) begin
            we = 1'b1; wa = cand[$urandom % cand.size()];
         end else if (($urandom % 16) == 0) begin
            we = 1'b1; wa = 0;
         end
         bus.id_valid = iv; bus.rs1_addr = 5'(r1); bus.rs2_addr = 5'(r2);
         bus.rs1_used = u1; bus.rs2_used = u2; bus.rd_addr = 5'(rdd); bus.rd_wen = rw;
         bus.flush = fl; bus.ex_ready = er;
         bus.wb_en = we; bus.wb_addr = 5'(wa); bus.wb_data = wd;
         #1;
         hz = (u1 && mbusy(r1, we, wa)) || (u2 && mbusy(r2, we, wa)) ||
              (rw && rdd != 0 && mcount(rdd) >= 3);
         exp_ready = !hz && !fl && (!m_ex_valid || er);
         exp_stall = iv && hz;
         checks++; if (bus.id_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, bus.id_ready, exp_ready); end
         checks++; if (bus.stall_raw !== exp_stall) begin fails++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, bus.stall_raw, exp_stall); end
         iss = iv && exp_ready;
         if (fl) begin
            m_ex_valid = 1'b0;
         end else if (iss || er) begin
            if (m_ex_valid && m_ex_wen && m_ex_rd != 0) post_ex[m_ex_rd]++;
            m_ex_valid = 1'b0;
            if (iss) begin
               m_ex_valid = 1'b1; m_ex_rd = rdd; m_ex_wen = rw;
               m_ex_d1 = mread(r1, we, wa, wd); m_ex_d2 = mread(r2, we, wa, wd);
            end
         end
         if (we && wa != 0) begin
            post_ex[wa]--;
            m_regs[wa] = wd;
         end
         tick();
         checks++; if (bus.ex_valid !== m_ex_valid) begin fails++; $display("FAIL rnd_ex_valid cyc %0d: got %b want %b", cyc, bus.ex_valid, m_ex_valid); end
         if (m_ex_valid) begin
            checks++;
            if (bus.ex_rs1_data !== m_ex_d1 || bus.ex_rs2_data !== m_ex_d2 ||
                bus.ex_rd_addr !== 5'(m_ex_rd) || bus.ex_rd_wen !== m_ex_wen) begin
               fails++;
               $display("FAIL rnd_ex_fields cyc %0d: got %h %h %0d %b want %h %h %0d %b", cyc,
                        bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_rd_addr, bus.ex_rd_wen,
                        m_ex_d1, m_ex_d2, m_ex_rd, m_ex_wen);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_raw_bypass();
      test_x0();
      test_saturation();
      test_flush();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
